// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: critical-word-first cache line fill with pending-store merge
module line_fill_ctrl #(
    parameter int REG_LOG    = 3,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    fill_req_valid,
    input  logic [ADDR_WIDTH-1:0]                   fill_req_addr,
    output logic                                    fill_req_ready,
    input  logic                                    st_valid,
    input  logic [REG_LOG-1:0]                      st_word,
    input  logic [DATA_WIDTH-1:0]                   st_data,
    output logic                                    mem_req_valid,
    input  logic                                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]                   mem_req_addr,
    input  logic                                    mem_resp_valid,
    output logic                                    mem_resp_ready,
    input  logic [DATA_WIDTH-1:0]                   mem_resp_data,
    output logic                                    crit_valid,
    output logic [DATA_WIDTH-1:0]                   crit_data,
    output logic                                    line_valid,
    input  logic                                    line_ready,
    output logic [2**REG_LOG-1:0][DATA_WIDTH-1:0]   line_data,
    output logic [ADDR_WIDTH-1:0]                   line_addr
);
    localparam int WORDS = 2**REG_LOG;
    localparam int OFF   = $clog2(DATA_WIDTH/8);
    localparam logic [ADDR_WIDTH-1:0] WMASK = ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));
    localparam logic [ADDR_WIDTH-1:0] LMASK = ~((ADDR_WIDTH'(1) << (OFF + REG_LOG)) - ADDR_WIDTH'(1));
    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;
    state_t                           state_q;
    logic [ADDR_WIDTH-1:0]            req_addr_q, line_addr_q;
    logic [REG_LOG-1:0]               crit_q, cnt_q, st_word_q, beat_idx;
    logic                             st_valid_q, crit_valid_q;
    logic [DATA_WIDTH-1:0]            st_data_q, crit_data_q, beat_data;
    logic [WORDS-1:0][DATA_WIDTH-1:0] line_q;
    assign beat_idx       = crit_q + cnt_q;
    assign beat_data      = (st_valid_q && beat_idx == st_word_q) ? st_data_q : mem_resp_data;
    assign fill_req_ready = state_q == IDLE;
    assign mem_req_valid  = state_q == REQ;
    assign mem_resp_ready = state_q == FILL;
    assign line_valid     = state_q == DONE;
    assign mem_req_addr   = req_addr_q;
    assign line_addr      = line_addr_q;
    assign line_data      = line_q;
    assign crit_valid     = crit_valid_q;
    assign crit_data      = crit_data_q;
    // Fill sequencing: capture request, issue memory request, place wrapped beats, hold line until taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            line_addr_q  <= '0;
            crit_q       <= '0;
            cnt_q        <= '0;
            st_valid_q   <= 1'b0;
            st_word_q    <= '0;
            st_data_q    <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            line_q       <= '0;
        end else begin
            crit_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (fill_req_valid) begin
                    req_addr_q  <= fill_req_addr & WMASK;
                    line_addr_q <= fill_req_addr & LMASK;
                    crit_q      <= fill_req_addr[OFF +: REG_LOG];
                    st_valid_q  <= st_valid;
                    st_word_q   <= st_word;
                    st_data_q   <= st_data;
                    state_q     <= REQ;
                end
                REQ: if (mem_req_ready) begin
                    cnt_q   <= '0;
                    state_q <= FILL;
                end
                FILL: if (mem_resp_valid) begin
                    line_q[beat_idx] <= beat_data;
                    cnt_q            <= cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        crit_valid_q <= 1'b1;
                        crit_data_q  <= beat_data;
                    end
                    if (cnt_q == REG_LOG'(WORDS - 1)) state_q <= DONE;
                end
                DONE: if (line_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_fill_ctrl.sv
// tb_line_fill_ctrl: directed scenario tests for line_fill_ctrl
module tb_line_fill_ctrl;
    logic             clk = 1'b0;
    logic             reset_n;
    logic             fill_req_valid;
    logic [63:0]      fill_req_addr;
    logic             fill_req_ready;
    logic             st_valid;
    logic [2:0]       st_word;
    logic [63:0]      st_data;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [63:0]      mem_req_addr;
    logic             mem_resp_valid;
    logic             mem_resp_ready;
    logic [63:0]      mem_resp_data;
    logic             crit_valid;
    logic [63:0]      crit_data;
    logic             line_valid;
    logic             line_ready;
    logic [7:0][63:0] line_data;
    logic [63:0]      line_addr;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] beats [8];
    int          gaps  [8];
    logic        crit_seen;
    logic [63:0] crit_val;

    line_fill_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .fill_req_valid(fill_req_valid), .fill_req_addr(fill_req_addr), .fill_req_ready(fill_req_ready),
        .st_valid(st_valid), .st_word(st_word), .st_data(st_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data),
        .crit_valid(crit_valid), .crit_data(crit_data),
        .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data), .line_addr(line_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_fill(input logic [63:0] addr, input logic sv, input logic [2:0] sw, input logic [63:0] sd);
        int n = 0;
        fill_req_valid = 1'b1;
        fill_req_addr  = addr;
        st_valid       = sv;
        st_word        = sw;
        st_data        = sd;
        while (!fill_req_ready && n < 50) begin tick(); n++; end
        if (n >= 50) begin tests++; fails++; $display("FAIL fill_accept_timeout"); end
        tick();
        fill_req_valid = 1'b0;
        st_valid       = 1'b0;
    endtask

    task automatic mem_handshake(input int wait_cycles);
        int n = 0;
        mem_req_ready = 1'b0;
        repeat (wait_cycles) tick();
        mem_req_ready = 1'b1;
        while (!mem_req_valid && n < 50) begin tick(); n++; end
        if (n >= 50) begin tests++; fails++; $display("FAIL mem_req_timeout"); end
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic send_beats(input logic use_gaps);
        for (int k = 0; k < 8; k++) begin
            int n = 0;
            if (use_gaps) begin
                mem_resp_valid = 1'b0;
                mem_resp_data  = 64'hBAD;
                repeat (gaps[k]) tick();
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = beats[k];
            while (!mem_resp_ready && n < 50) begin tick(); n++; end
            if (n >= 50) begin tests++; fails++; $display("FAIL beat_timeout k=%0d", k); end
            tick();
            if (k == 0) begin
                crit_seen = crit_valid;
                crit_val  = crit_data;
            end
        end
        mem_resp_valid = 1'b0;
    endtask

    task automatic finish_line();
        int n = 0;
        line_ready = 1'b1;
        while (!line_valid && n < 50) begin tick(); n++; end
        if (n >= 50) begin tests++; fails++; $display("FAIL line_timeout"); end
        tick();
        line_ready = 1'b0;
    endtask

    task automatic check_words(input string name, input logic [63:0] base, input int crit);
        for (int j = 0; j < 8; j++) begin
            logic [63:0] e;
            e = base + 64'((j - crit) & 7);
            tests++;
            if (line_data[j] !== e) begin
                fails++;
                $display("FAIL %s word%0d got=%h exp=%h", name, j, line_data[j], e);
            end
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({mem_req_valid, mem_resp_ready, crit_valid, line_valid} !== 4'b0) begin
            fails++; $display("FAIL reset_ctrl got=%b exp=0000", {mem_req_valid, mem_resp_ready, crit_valid, line_valid});
        end
        tests++;
        if ({crit_data, line_addr, mem_req_addr} !== '0 || line_data !== '0) begin
            fails++; $display("FAIL reset_data got crit=%h laddr=%h maddr=%h exp=0", crit_data, line_addr, mem_req_addr);
        end
        reset_n = 1'b1;
        tick();
        tests++;
        if (fill_req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", fill_req_ready); end
    endtask

    task automatic test_aligned();
        for (int k = 0; k < 8; k++) beats[k] = 64'h10 + 64'(k);
        send_fill(64'h1000, 1'b0, 3'd0, 64'h0);
        tests++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1000 || fill_req_ready !== 1'b0) begin
            fails++; $display("FAIL aligned_req got v=%b a=%h r=%b exp v=1 a=1000 r=0", mem_req_valid, mem_req_addr, fill_req_ready);
        end
        mem_handshake(0);
        send_beats(1'b0);
        tests++;
        if (line_valid !== 1'b1 || line_addr !== 64'h1000) begin
            fails++; $display("FAIL aligned_line got v=%b a=%h exp v=1 a=1000", line_valid, line_addr);
        end
        tests++;
        if (crit_seen !== 1'b1 || crit_val !== 64'h10) begin
            fails++; $display("FAIL aligned_crit got v=%b d=%h exp v=1 d=10", crit_seen, crit_val);
        end
        tests++;
        if (crit_valid !== 1'b0) begin fails++; $display("FAIL aligned_crit_pulse got=%b exp=0", crit_valid); end
        check_words("aligned", 64'h10, 0);
        finish_line();
        tests++;
        if (fill_req_ready !== 1'b1 || line_valid !== 1'b0) begin
            fails++; $display("FAIL aligned_idle got r=%b v=%b exp r=1 v=0", fill_req_ready, line_valid);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 8; k++) beats[k] = 64'hA0 + 64'(k);
        send_fill(64'h1028, 1'b0, 3'd0, 64'h0);
        tests++;
        if (mem_req_addr !== 64'h1028) begin fails++; $display("FAIL wrap_req_addr got=%h exp=1028", mem_req_addr); end
        mem_handshake(0);
        send_beats(1'b0);
        tests++;
        if (crit_val !== 64'hA0 || line_addr !== 64'h1000) begin
            fails++; $display("FAIL wrap_crit got d=%h a=%h exp d=a0 a=1000", crit_val, line_addr);
        end
        check_words("wrap", 64'hA0, 5);
        finish_line();
    endtask

    task automatic test_merge();
        for (int k = 0; k < 8; k++) beats[k] = 64'hB0 + 64'(k);
        send_fill(64'h102D, 1'b1, 3'd0, 64'hDEAD);
        tests++;
        if (mem_req_addr !== 64'h1028) begin fails++; $display("FAIL merge_req_addr got=%h exp=1028", mem_req_addr); end
        mem_handshake(0);
        send_beats(1'b0);
        tests++;
        if (line_data[0] !== 64'hDEAD || line_data[1] !== 64'hB4 || line_data[7] !== 64'hB2 || line_data[5] !== 64'hB0) begin
            fails++; $display("FAIL merge_w0 got w0=%h w1=%h w5=%h w7=%h exp dead b4 b0 b2", line_data[0], line_data[1], line_data[5], line_data[7]);
        end
        tests++;
        if (crit_val !== 64'hB0) begin fails++; $display("FAIL merge_w0_crit got=%h exp=b0", crit_val); end
        finish_line();
        send_fill(64'h1028, 1'b1, 3'd5, 64'hDEAD);
        mem_handshake(0);
        send_beats(1'b0);
        tests++;
        if (crit_val !== 64'hDEAD || line_data[5] !== 64'hDEAD || line_data[6] !== 64'hB1 || line_data[0] !== 64'hB3) begin
            fails++; $display("FAIL merge_w5 got crit=%h w5=%h w6=%h w0=%h exp dead dead b1 b3", crit_val, line_data[5], line_data[6], line_data[0]);
        end
        finish_line();
    endtask

    task automatic test_backpressure();
        logic [7:0][63:0] snap;
        int bad = 0;
        int n = 0;
        for (int k = 0; k < 8; k++) beats[k] = 64'hC0DE_0000 + 64'(k);
        gaps = '{0, 2, 1, 0, 3, 0, 1, 2};
        send_fill(64'h3010, 1'b0, 3'd0, 64'h0);
        mem_req_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h3010) bad++;
            tick();
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL bp_req_hold got bad_cycles=%0d exp=0", bad); end
        mem_handshake(0);
        send_beats(1'b1);
        check_words("bp", 64'hC0DE_0000, 2);
        tests++;
        if (line_addr !== 64'h3000 || crit_val !== 64'hC0DE_0000) begin
            fails++; $display("FAIL bp_addr got a=%h c=%h exp 3000 c0de0000", line_addr, crit_val);
        end
        snap = line_data;
        bad  = 0;
        line_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (line_valid !== 1'b1 || line_data !== snap || line_addr !== 64'h3000) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL bp_line_hold got bad_cycles=%0d exp=0", bad); end
        finish_line();
        n = 0;
    endtask

    task automatic test_reset_mid();
        send_fill(64'h4000, 1'b1, 3'd1, 64'h5555);
        mem_handshake(0);
        for (int k = 0; k < 3; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 64'hEE + 64'(k);
            tick();
        end
        mem_resp_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({mem_req_valid, mem_resp_ready, crit_valid, line_valid} !== 4'b0 || line_data !== '0 || line_addr !== '0 || mem_req_addr !== '0) begin
            fails++; $display("FAIL midreset_outputs got ctrl=%b laddr=%h maddr=%h exp all zero", {mem_req_valid, mem_resp_ready, crit_valid, line_valid}, line_addr, mem_req_addr);
        end
        tick();
        reset_n = 1'b1;
        tick();
        tests++;
        if (fill_req_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready got=%b exp=1", fill_req_ready); end
        for (int k = 0; k < 8; k++) beats[k] = 64'hC0 + 64'(k);
        send_fill(64'h2018, 1'b0, 3'd1, 64'h5555);
        mem_handshake(0);
        send_beats(1'b0);
        check_words("midreset", 64'hC0, 3);
        finish_line();
    endtask

    task automatic test_done_hold();
        int bad = 0;
        for (int k = 0; k < 8; k++) beats[k] = 64'h70 + 64'(k);
        send_fill(64'h5000, 1'b0, 3'd0, 64'h0);
        mem_handshake(0);
        send_beats(1'b0);
        fill_req_valid = 1'b1;
        fill_req_addr  = 64'h6038;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hFFFF;
        line_ready     = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (fill_req_ready !== 1'b0 || line_valid !== 1'b1) bad++;
            tick();
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL done_hold got bad_cycles=%0d exp=0", bad); end
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        tests++;
        if (fill_req_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_resp_ready !== 1'b0) begin
            fails++; $display("FAIL done_no_accept got r=%b mv=%b rr=%b exp 1 0 0", fill_req_ready, mem_req_valid, mem_resp_ready);
        end
        tick();
        fill_req_valid = 1'b0;
        tests++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h6038) begin
            fails++; $display("FAIL done_next_req got v=%b a=%h exp 1 6038", mem_req_valid, mem_req_addr);
        end
        tests++;
        if (line_data[0] !== 64'h70 || line_data[7] !== 64'h77) begin
            fails++; $display("FAIL idle_beats_ignored got w0=%h w7=%h exp 70 77", line_data[0], line_data[7]);
        end
        mem_handshake(1);
        for (int k = 0; k < 8; k++) beats[k] = 64'h90 + 64'(k);
        send_beats(1'b0);
        check_words("after_done", 64'h90, 7);
        finish_line();
    endtask

    initial begin
        reset_n        = 1'b0;
        fill_req_valid = 1'b0;
        fill_req_addr  = '0;
        st_valid       = 1'b0;
        st_word        = '0;
        st_data        = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        line_ready     = 1'b0;
        tick();
        tick();
        test_reset();
        test_aligned();
        test_wrap();
        test_merge();
        test_backpressure();
        test_reset_mid();
        test_done_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
